// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for control-flow handling:
//   - RV32 opcodes for JAL, JALR and conditional BRANCH
//   - funct3 encodings of the branch conditions
//   - br_state_t, the two-phase state of branch_resolve (IDLE / RESOLVE)
//   - is_cf_op(), which is true for any opcode that redirects the PC
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    RESOLVE = 1'b1
  } br_state_t;

  function automatic logic is_cf_op(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
// Purely combinational branch-condition evaluator.
// Ports:
//   funct3   in   branch condition select
//   rs1_val  in   XLEN  first operand
//   rs2_val  in   XLEN  second operand
//   cond     out  condition holds (0 for the reserved encodings)
//   illegal  out  funct3 is 010 or 011, which have no branch meaning
// ---------------------------------------------------------------------------
module branch_cmp
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            cond,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_val == rs2_val);
  assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
  assign lt_u = (rs1_val < rs2_val);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Resolves JAL / JALR / conditional branches for a PC that alternates
// between an INC4 phase and a STALL phase. The instruction at IP is
// captured while in IDLE and the registered decision is presented during
// the following RESOLVE cycle, which is when the PC applies it.
//
// Optional build macro: BRANCH_STATS_EN
//   defined   -> saturating 32-bit counters of resolved and taken branches
//   undefined -> br_count / taken_count tied to 0, no counter flops
//
// Ports:
//   CLK          in   rising-edge clock
//   RESET        in   asynchronous active-high reset
//   OP           in   opcode of the instruction at IP
//   funct3       in   branch condition select
//   imm          in   XLEN  sign-extended immediate
//   rs1_val      in   XLEN  register source 1
//   rs2_val      in   XLEN  register source 2
//   IP           in   XLEN  current instruction pointer
//   PC_def       in   XLEN  IP+4
//   b_taken      out  redirect request (RESOLVE only)
//   up_amt       out  XLEN  offset added to IP on redirect (RESOLVE only)
//   link_val     out  XLEN  return address for JAL/JALR (holds in IDLE)
//   link_we      out  one-cycle writeback strobe for link_val
//   misalign     out  taken target has bit 1 set (RESOLVE only)
//   illegal_br   out  branch with reserved funct3 (RESOLVE only)
//   br_count     out  32  resolved-branch counter
//   taken_count  out  32  taken-branch counter
// ---------------------------------------------------------------------------
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [6:0]      OP,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] IP,
  input  logic [XLEN-1:0] PC_def,
  output logic            b_taken,
  output logic [XLEN-1:0] up_amt,
  output logic [XLEN-1:0] link_val,
  output logic            link_we,
  output logic            misalign,
  output logic            illegal_br,
  output logic [31:0]     br_count,
  output logic [31:0]     taken_count
);

  localparam logic [XLEN-1:0] CLR_LSB = {{(XLEN-1){1'b1}}, 1'b0};

  br_state_t state;

  logic            cmp_cond;
  logic            cmp_illegal;

  logic            capture;
  logic            cap_taken;
  logic [XLEN-1:0] cap_off;
  logic            cap_link_we;
  logic            cap_illegal;
  logic            cap_misalign;
  logic [XLEN-1:0] jalr_target;
  logic [1:0]      target_lo;

  logic            taken_r;
  logic [XLEN-1:0] off_r;
  logic [XLEN-1:0] link_r;
  logic            link_we_r;
  logic            misalign_r;
  logic            illegal_r;

  branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .cond    (cmp_cond),
    .illegal (cmp_illegal)
  );

  // The PC keeps IP (and thus OP) stable through RESOLVE, so capturing only
  // from IDLE stops the re-presented instruction from triggering twice.
  assign capture = (state == IDLE) && is_cf_op(OP);

  // JALR offset is expressed relative to IP so the PC can use one adder
  // for every redirect; the subtract wraps modulo 2^XLEN.
  assign jalr_target = (rs1_val + imm) & CLR_LSB;

  always_comb begin
    cap_taken   = 1'b0;
    cap_off     = imm;
    cap_link_we = 1'b0;
    cap_illegal = 1'b0;
    case (OP)
      OP_JAL: begin
        cap_taken   = 1'b1;
        cap_link_we = 1'b1;
      end
      OP_JALR: begin
        cap_taken   = 1'b1;
        cap_off     = jalr_target - IP;
        cap_link_we = 1'b1;
      end
      OP_BRANCH: begin
        cap_taken   = cmp_cond;
        cap_illegal = cmp_illegal;
      end
      default: ;
    endcase
  end

  // Only bit 1 of IP+offset matters for misalignment, so add the low bits.
  assign target_lo    = IP[1:0] + cap_off[1:0];
  assign cap_misalign = cap_taken & target_lo[1];

  // ---- capture stage: IDLE -> RESOLVE --------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= capture ? RESOLVE : IDLE;
        RESOLVE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      taken_r    <= 1'b0;
      link_we_r  <= 1'b0;
      misalign_r <= 1'b0;
      illegal_r  <= 1'b0;
      link_r     <= '0;
    end else if (capture) begin
      taken_r    <= cap_taken;
      link_we_r  <= cap_link_we;
      misalign_r <= cap_misalign;
      illegal_r  <= cap_illegal;
      // link_val keeps the last JAL/JALR return address across branches.
      if (cap_link_we) begin
        link_r <= PC_def;
      end
    end
  end

  // Offset is masked by state on the output, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (capture) begin
      off_r <= cap_off;
    end
  end

  // ---- resolve stage: outputs are qualified by RESOLVE ---------------------
  assign b_taken    = (state == RESOLVE) & taken_r;
  assign up_amt     = (state == RESOLVE) ? off_r : '0;
  assign link_we    = (state == RESOLVE) & link_we_r;
  assign misalign   = (state == RESOLVE) & misalign_r;
  assign illegal_br = (state == RESOLVE) & illegal_r;
  assign link_val   = link_r;

`ifdef BRANCH_STATS_EN
  logic        is_br_r;
  logic [31:0] br_cnt_r;
  logic [31:0] taken_cnt_r;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      is_br_r <= 1'b0;
    end else if (capture) begin
      is_br_r <= (OP == OP_BRANCH);
    end
  end

  // Counters advance at the end of the RESOLVE cycle and stick at all-ones.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      br_cnt_r    <= '0;
      taken_cnt_r <= '0;
    end else if ((state == RESOLVE) && is_br_r) begin
      if (br_cnt_r != 32'hFFFF_FFFF) begin
        br_cnt_r <= br_cnt_r + 32'd1;
      end
      if (taken_r && (taken_cnt_r != 32'hFFFF_FFFF)) begin
        taken_cnt_r <= taken_cnt_r + 32'd1;
      end
    end
  end

  assign br_count    = br_cnt_r;
  assign taken_count = taken_cnt_r;
`else
  assign br_count    = 32'd0;
  assign taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  import cpu_pkg::*;

  localparam logic [6:0] OP_NOP = 7'b0010011;

  logic        CLK;
  logic        RESET;
  logic [6:0]  OP;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1_val, rs2_val, IP, PC_def;
  logic        b_taken;
  logic [31:0] up_amt, link_val;
  logic        link_we, misalign, illegal_br;
  logic [31:0] br_count, taken_count;

  int checks = 0;
  int errors = 0;

  branch_resolve #(.XLEN(32)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .OP          (OP),
    .funct3      (funct3),
    .imm         (imm),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .IP          (IP),
    .PC_def      (PC_def),
    .b_taken     (b_taken),
    .up_amt      (up_amt),
    .link_val    (link_val),
    .link_we     (link_we),
    .misalign    (misalign),
    .illegal_br  (illegal_br),
    .br_count    (br_count),
    .taken_count (taken_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] ip;
    logic        cf;
    logic        exp_taken;
    logic [31:0] exp_up;
    logic [31:0] exp_link;
    logic        exp_we;
    logic        exp_mis;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] im, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] ip,
                              input logic cf, input logic t, input logic [31:0] up,
                              input logic [31:0] lk, input logic we,
                              input logic mis, input logic ill);
    vec_t v;
    v.op = op; v.f3 = f3; v.imm = im; v.rs1 = r1; v.rs2 = r2; v.ip = ip;
    v.cf = cf; v.exp_taken = t; v.exp_up = up; v.exp_link = lk;
    v.exp_we = we; v.exp_mis = mis; v.exp_ill = ill;
    return v;
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] im,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] ip);
    OP = op; funct3 = f3; imm = im; rs1_val = r1; rs2_val = r2;
    IP = ip; PC_def = ip + 32'd4;
  endtask

  int pulses;

  initial begin
    // op, f3, imm, rs1, rs2, ip, cf, taken, up, link, we, mis, ill
    vecs[0]  = mk(OP_BRANCH, F3_BEQ,  32'hFFFF_FFF8, 32'd5, 32'd5, 32'h40,
                  1, 1, 32'hFFFF_FFF8, 32'h0, 0, 0, 0);
    vecs[1]  = mk(OP_BRANCH, F3_BLT,  32'h10, 32'hFFFF_FFFF, 32'd1, 32'h100,
                  1, 1, 32'h10, 32'h0, 0, 0, 0);
    vecs[2]  = mk(OP_BRANCH, F3_BLTU, 32'h10, 32'hFFFF_FFFF, 32'd1, 32'h100,
                  1, 0, 32'h10, 32'h0, 0, 0, 0);
    vecs[3]  = mk(OP_JALR,   3'b000,  32'd4, 32'h103, 32'd0, 32'h20,
                  1, 1, 32'hE6, 32'h24, 1, 1, 0);
    vecs[4]  = mk(OP_BRANCH, F3_BNE,  32'h8, 32'd3, 32'd3, 32'h200,
                  1, 0, 32'h8, 32'h24, 0, 0, 0);
    vecs[5]  = mk(OP_BRANCH, F3_BGE,  32'h6, 32'd1, 32'hFFFF_FFFF, 32'h300,
                  1, 1, 32'h6, 32'h24, 0, 1, 0);
    vecs[6]  = mk(OP_BRANCH, F3_BGEU, 32'hC, 32'd1, 32'hFFFF_FFFF, 32'h0,
                  1, 0, 32'hC, 32'h24, 0, 0, 0);
    vecs[7]  = mk(OP_JAL,    3'b000,  32'h800, 32'd0, 32'd0, 32'h1000,
                  1, 1, 32'h800, 32'h1004, 1, 0, 0);
    vecs[8]  = mk(OP_BRANCH, 3'b010,  32'h4, 32'd0, 32'd0, 32'h50,
                  1, 0, 32'h4, 32'h1004, 0, 0, 1);
    vecs[9]  = mk(OP_BRANCH, 3'b011,  32'h4, 32'd1, 32'd2, 32'h50,
                  1, 0, 32'h4, 32'h1004, 0, 0, 1);
    vecs[10] = mk(OP_JALR,   3'b000,  32'd0, 32'h10, 32'd0, 32'h100,
                  1, 1, 32'hFFFF_FF10, 32'h104, 1, 0, 0);
    vecs[11] = mk(OP_BRANCH, F3_BGE,  32'h4, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h400,
                  1, 1, 32'h4, 32'h104, 0, 0, 0);
    vecs[12] = mk(OP_NOP,    3'b000,  32'h4, 32'd0, 32'd0, 32'h500,
                  0, 0, 32'h0, 32'h104, 0, 0, 0);

    // Reset state: outputs are 0 while RESET is held.
    RESET = 1'b1;
    drive(OP_NOP, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("rst_b_taken", {31'd0, b_taken}, 32'd0);
    chk("rst_up_amt", up_amt, 32'd0);
    chk("rst_link_val", link_val, 32'd0);
    chk("rst_link_we", {31'd0, link_we}, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_taken_count", taken_count, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Table-driven: capture in IDLE, check in RESOLVE, then back to IDLE.
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      drive(vecs[i].op, vecs[i].f3, vecs[i].imm, vecs[i].rs1, vecs[i].rs2, vecs[i].ip);
      #1;
      chk($sformatf("v%0d_idle_b_taken", i), {31'd0, b_taken}, 32'd0);
      @(negedge CLK);
      if (vecs[i].cf) begin
        chk($sformatf("v%0d_b_taken", i), {31'd0, b_taken}, {31'd0, vecs[i].exp_taken});
        chk($sformatf("v%0d_up_amt", i), up_amt, vecs[i].exp_up);
        chk($sformatf("v%0d_link_val", i), link_val, vecs[i].exp_link);
        chk($sformatf("v%0d_link_we", i), {31'd0, link_we}, {31'd0, vecs[i].exp_we});
        chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, vecs[i].exp_mis});
        chk($sformatf("v%0d_illegal", i), {31'd0, illegal_br}, {31'd0, vecs[i].exp_ill});
        OP = OP_NOP;
        @(negedge CLK);
      end
      chk($sformatf("v%0d_after_b_taken", i), {31'd0, b_taken}, 32'd0);
      chk($sformatf("v%0d_after_link_we", i), {31'd0, link_we}, 32'd0);
      chk($sformatf("v%0d_after_up_amt", i), up_amt, 32'd0);
    end

    // OP held at BRANCH for 4 cycles: pulses in cycles 2 and 4 only.
    @(negedge CLK);
    drive(OP_BRANCH, F3_BEQ, 32'h10, 32'd7, 32'd7, 32'h600);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk($sformatf("hold_c%0d_b_taken", c + 2), {31'd0, b_taken}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (b_taken) pulses++;
    end
    chk("hold_pulse_count", pulses, 32'd2);
    OP = OP_NOP;
    @(negedge CLK);

    // RESET between edges during RESOLVE discards the JAL decision.
    drive(OP_JAL, 3'b000, 32'h40, 32'd0, 32'd0, 32'h700);
    @(negedge CLK);
    chk("rstmid_pre_b_taken", {31'd0, b_taken}, 32'd1);
    chk("rstmid_pre_link_we", {31'd0, link_we}, 32'd1);
    chk("rstmid_pre_link_val", link_val, 32'h704);
    #2;
    RESET = 1'b1;
    #1;
    chk("rstmid_b_taken", {31'd0, b_taken}, 32'd0);
    chk("rstmid_link_we", {31'd0, link_we}, 32'd0);
    chk("rstmid_link_val", link_val, 32'd0);
    OP = OP_NOP;
    @(negedge CLK);
    chk("rstmid_edge_b_taken", {31'd0, b_taken}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rstmid_idle_link_we", {31'd0, link_we}, 32'd0);

    // Statistics: 3 branches, 2 taken, starting from a fresh reset.
    drive(OP_BRANCH, F3_BEQ, 32'h8, 32'd1, 32'd1, 32'h800);
    @(negedge CLK);
    chk("post_rst_capture", {31'd0, b_taken}, 32'd1);
    drive(OP_BRANCH, F3_BNE, 32'h8, 32'd1, 32'd1, 32'h804);
    @(negedge CLK);
    @(negedge CLK);
    chk("stats_bne_taken", {31'd0, b_taken}, 32'd0);
    drive(OP_BRANCH, F3_BLT, 32'h8, 32'hFFFF_FFFE, 32'd3, 32'h808);
    @(negedge CLK);
    @(negedge CLK);
    chk("stats_blt_taken", {31'd0, b_taken}, 32'd1);
    OP = OP_NOP;
    @(negedge CLK);
`ifdef BRANCH_STATS_EN
    chk("stats_br_count", br_count, 32'd3);
    chk("stats_taken_count", taken_count, 32'd2);
`else
    chk("stats_br_count", br_count, 32'd0);
    chk("stats_taken_count", taken_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
